seq_scan_ctrl: RTL

- Controller for the bit-serial pattern detection datapath.
- Accepts parallel words over a valid/ready handshake and serialises them MSB-first into a programmable pattern matcher (length 1..PMAX, overlapping or non-overlapping).
- Counts matches over a configured number of words, then signals completion.
- Sits between a word-oriented producer and the team's sequence-detection logic; one job in flight at a time.

---
 rtl/seq_scan_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: accepts parallel words over valid/ready, shifts each word out MSB-first
// into a programmable pattern matcher and counts matches over a configured number of words.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   cfg_pattern  pattern; bit cfg_len-1 is expected first, bit 0 last
//   cfg_len      pattern length in bits (1..PMAX)
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   cfg_words    number of words in the job
//   start        job request, sampled only while idle
//   busy         job active
//   in_valid     word available
//   in_data      word to scan, MSB first
//   in_ready     controller can accept a word
//   match_pulse  one-cycle pulse per match
//   match_count  saturating match count for the current/last job
//   done         one-cycle pulse at job end
//   err_cfg      one-cycle pulse when a start is rejected
module seq_scan_ctrl #(
  parameter int unsigned DW   = 8,
  parameter int unsigned PMAX = 8,
  parameter int unsigned CW   = 16,
  localparam int unsigned LW  = $clog2(PMAX) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PMAX-1:0] cfg_pattern,
  input  logic [LW-1:0]   cfg_len,
  input  logic            cfg_overlap,
  input  logic [CW-1:0]   cfg_words,
  input  logic            start,
  output logic            busy,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic            match_pulse,
  output logic [CW-1:0]   match_count,
  output logic            done,
  output logic            err_cfg
);

  localparam int unsigned BW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StFinish} state_e;

  state_e          state_q, state_d;
  logic [PMAX-1:0] pat_q, pat_d;
  logic [LW-1:0]   len_q, len_d;
  logic            ovl_q, ovl_d;
  logic [CW-1:0]   words_q, words_d;
  logic [PMAX-1:0] hist_q, hist_d;
  logic [LW-1:0]   fill_q, fill_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DW-1:0]   word_q, word_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pulse_q, pulse_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            cfg_ok;
  logic            shift_bit;
  logic [PMAX-1:0] hist_shift;
  logic [PMAX-1:0] len_mask;
  logic [LW-1:0]   fill_inc;
  logic            is_match;

  assign cfg_ok = (cfg_len != '0) && (32'(cfg_len) <= PMAX) && (cfg_words != '0);

  // Matcher datapath: history after this cycle's shift, compared over the low len_q bits.
  always_comb begin
    shift_bit  = word_q[bit_q];
    hist_shift = hist_q << 1;
    hist_shift[0] = shift_bit;
    for (int unsigned i = 0; i < PMAX; i++) begin
      len_mask[i] = (i < 32'(len_q));
    end
    fill_inc = fill_q + LW'(1);
    is_match = (fill_inc >= len_q) && (((hist_shift ^ pat_q) & len_mask) == '0);
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    words_d = words_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    bit_d   = bit_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (!cfg_ok) begin
            err_d = 1'b1;
          end else begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            ovl_d   = cfg_overlap;
            words_d = cfg_words;
            hist_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (in_valid) begin
          word_d  = in_data;
          bit_d   = BW'(DW - 1);
          state_d = StShift;
        end
      end
      StShift: begin
        hist_d = hist_shift;
        fill_d = (fill_inc >= len_q) ? len_q : fill_inc;
        if (is_match) begin
          pulse_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
          // Non-overlapping: the next match must be built from entirely fresh bits.
          if (!ovl_q) fill_d = '0;
        end
        if (bit_q == '0) begin
          words_d = words_q - CW'(1);
          if (words_q == CW'(1)) begin
            done_d  = 1'b1;
            state_d = StFinish;
          end else begin
            state_d = StLoad;
          end
        end else begin
          bit_d = bit_q - BW'(1);
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      words_q <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      words_q <= words_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign in_ready    = (state_q == StLoad);
  assign match_pulse = pulse_q;
  assign match_count = cnt_q;
  assign done        = done_q;
  assign err_cfg     = err_q;

endmodule
